// File: rtl/vec_proc_unit_pkg.sv
// Shared opcodes, FSM states, datapath widths and saturation helpers for the vector processor.
package vec_proc_unit_pkg;

  localparam int LANE_W = 16;
  localparam int ACC_W  = 35;
  localparam int RAD_W  = 34;
  localparam int ROOT_W = 17;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DOT    = 4'd3;
  localparam logic [3:0] OP_SCALE  = 4'd4;
  localparam logic [3:0] OP_LENGTH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LANE = 2'd1,
    ST_SQRT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [LANE_W-1:0] sat_s16(input logic signed [35:0] v);
    if (v > 36'sd32767)
      return 16'h7FFF;
    else if (v < -36'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  function automatic logic [LANE_W-1:0] sat_u16(input logic [35:0] v);
    if (v > 36'h0_0000_FFFF)
      return 16'hFFFF;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/vp_isqrt.sv
// Restoring integer square root, one root bit per cycle; the load cycle already resolves the first bit.
module vp_isqrt
  import vec_proc_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RAD_W-1:0]  radicand,
  output logic [ROOT_W-1:0] root,
  output logic              valid
);

  logic [19:0]       rem, src_rem, rem_sh, trial, rem_new;
  logic [ROOT_W-1:0] src_q, q_new;
  logic [RAD_W-1:0]  d, src_d;
  logic [4:0]        steps;
  logic              ge;

  always_comb begin
    src_rem = load ? '0 : rem;
    src_q   = load ? '0 : root;
    src_d   = load ? radicand : d;
    rem_sh  = (src_rem << 2) | {18'b0, src_d[RAD_W-1 -: 2]};
    trial   = {1'b0, src_q, 2'b01};
    ge      = (rem_sh >= trial);
    rem_new = ge ? (rem_sh - trial) : rem_sh;
    q_new   = (src_q << 1) | {{(ROOT_W-1){1'b0}}, ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      root  <= '0;
      d     <= '0;
      steps <= '0;
    end else if (load || (steps != 5'd0 && steps != 5'd17)) begin
      rem   <= rem_new;
      root  <= q_new;
      d     <= src_d << 2;
      steps <= load ? 5'd1 : steps + 5'd1;
    end
  end

  assign valid = (steps == 5'd17);

endmodule

// File: rtl/vec_proc_unit.sv
// Lane-serial 8.8 fixed-point vector unit: one shared multiplier, saturating lanes, DOT and LENGTH reductions.
module vec_proc_unit
  import vec_proc_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int VECTOR_WIDTH = 4,
  parameter int FRAC_BITS    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [3:0]                         operation,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_a,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_b,
  input  logic [DATA_WIDTH-1:0]              scalar,
  output logic                               busy,
  output logic                               done,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] result,
  output logic                               result_valid
);

  localparam int VW = VECTOR_WIDTH * DATA_WIDTH;

  state_e state, state_next;

  logic [1:0]              cnt;
  logic [3:0]              op_q;
  logic [VW-1:0]           a_q, b_q, a_sh, b_sh;
  logic [VW-1:0]           lane_buf, lane_buf_next, final_res;
  logic [DATA_WIDTH-1:0]   scalar_q;
  logic [LANE_W-1:0]       lane_a, lane_b, lane_res;
  logic signed [16:0]      mul_x, mul_y, sum, diff;
  logic signed [33:0]      prod, prod_sh;
  logic signed [ACC_W-1:0] acc, acc_next, acc_sh;
  logic                    accept, sqrt_load, root_valid;
  logic [ROOT_W-1:0]       root;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    sqrt_load  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_LANE;
      ST_LANE: begin
        busy = 1'b1;
        if (cnt == 2'd3) begin
          if (op_q == OP_LENGTH) begin
            state_next = ST_SQRT;
            sqrt_load  = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_SQRT: begin
        busy = 1'b1;
        if (root_valid) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = start ? ST_LANE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign result_valid = done;

  // Lane cnt is rotated into the top slot so one fixed slice feeds the shared multiplier.
  always_comb begin
    a_sh   = a_q << {cnt, 4'b0000};
    b_sh   = b_q << {cnt, 4'b0000};
    lane_a = a_sh[VW-1 -: LANE_W];
    lane_b = b_sh[VW-1 -: LANE_W];
    sum    = {lane_a[15], lane_a} + {lane_b[15], lane_b};
    diff   = {lane_a[15], lane_a} - {lane_b[15], lane_b};

    mul_x = {lane_a[15], lane_a};
    mul_y = {lane_b[15], lane_b};
    if (op_q == OP_SCALE) begin
      mul_x = {1'b0, lane_a};
      mul_y = {1'b0, scalar_q};
    end else if (op_q == OP_LENGTH) begin
      mul_x = {1'b0, lane_a};
      mul_y = {1'b0, lane_a};
    end
    prod     = mul_x * mul_y;
    prod_sh  = prod >>> FRAC_BITS;
    acc_next = acc + {prod[33], prod};
    acc_sh   = acc_next >>> FRAC_BITS;

    case (op_q)
      OP_ADD:   lane_res = sat_s16({{19{sum[16]}}, sum});
      OP_SUB:   lane_res = sat_s16({{19{diff[16]}}, diff});
      OP_MUL:   lane_res = sat_s16({{2{prod_sh[33]}}, prod_sh});
      OP_SCALE: lane_res = sat_u16({2'b00, prod_sh});
      default:  lane_res = '0;
    endcase
    lane_buf_next = lane_buf | ({lane_res, {(VW-LANE_W){1'b0}}} >> {cnt, 4'b0000});

    if (state == ST_SQRT) begin
      final_res = {sat_u16({19'b0, root}), {(VW-LANE_W){1'b0}}};
    end else begin
      case (op_q)
        OP_ADD, OP_SUB, OP_MUL, OP_SCALE: final_res = lane_buf_next;
        OP_DOT:  final_res = {sat_s16({acc_sh[ACC_W-1], acc_sh}), {(VW-LANE_W){1'b0}}};
        default: final_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      cnt      <= '0;
      lane_buf <= '0;
      acc      <= '0;
      result   <= '0;
    end else begin
      if (accept) begin
        op_q     <= operation;
        a_q      <= vec_a;
        b_q      <= vec_b;
        scalar_q <= scalar;
        cnt      <= '0;
        lane_buf <= '0;
        acc      <= '0;
      end else if (state == ST_LANE) begin
        cnt      <= cnt + 2'd1;
        lane_buf <= lane_buf_next;
        acc      <= acc_next;
      end
      // The final lane (or the last root bit) is folded in on the edge that enters DONE.
      if (state_next == ST_DONE) result <= final_res;
    end
  end

  vp_isqrt u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .load     (sqrt_load),
    .radicand (acc_next[RAD_W-1:0]),
    .root     (root),
    .valid    (root_valid)
  );

endmodule

// File: tb/tb_vec_proc_unit.sv
// tb/tb_vec_proc_unit.sv - scoreboard bench for vec_proc_unit
module tb_vec_proc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  operation = '0;
    logic [63:0] vec_a = '0, vec_b = '0;
    logic [15:0] scalar = '0;
    logic        busy, done, result_valid;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    vec_proc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .operation    (operation),
        .vec_a        (vec_a),
        .vec_b        (vec_b),
        .scalar       (scalar),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid)
    );

    function automatic logic [15:0] m_sat_s(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic longint m_isqrt(input longint n);
        longint lo, hi, mid;
        lo = 0;
        hi = 64'd1 << 18;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                          input logic [15:0] s);
        logic [63:0] r;
        logic [15:0] ai, bi;
        longint x, y, v, acc, rt;
        r = '0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            ai = a[63-16*i -: 16];
            bi = b[63-16*i -: 16];
            x = longint'($signed(ai));
            y = longint'($signed(bi));
            case (op)
                4'd0: r[63-16*i -: 16] = m_sat_s(x + y);
                4'd1: r[63-16*i -: 16] = m_sat_s(x - y);
                4'd2: r[63-16*i -: 16] = m_sat_s((x * y) >>> 8);
                4'd3: acc = acc + x * y;
                4'd4: begin
                    v = (longint'(ai) * longint'(s)) >> 8;
                    r[63-16*i -: 16] = (v > 65535) ? 16'hFFFF : v[15:0];
                end
                4'd5: acc = acc + longint'(ai) * longint'(ai);
                default: ;
            endcase
        end
        if (op == 4'd3) r[63:48] = m_sat_s(acc >>> 8);
        if (op == 4'd5) begin
            rt = m_isqrt(acc);
            r[63:48] = (rt > 65535) ? 16'hFFFF : rt[15:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [15:0] s);
        operation = op;
        vec_a = a;
        vec_b = b;
        scalar = s;
        start = 1'b1;
        exp_q.push_back(model(op, a, b, s));
        tick();
        start = 1'b0;
        operation = ~op;
        vec_a = ~a;
        vec_b = ~b;
        scalar = ~s;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc = busy ? 1 : 0;
        while (!done && lat < 64) begin
            tick();
            lat++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b rv=%b result=%h expected 0/0/0/0", busy, done, result_valid, result);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_scale();
        int lat, bc;
        logic [63:0] exp;
        issue(4'd4, 64'hFF00_0000_0000_FF00, 64'h0, 16'h0080);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL scale_latency: got %0d expected 5", lat);
        end
        checks++;
        if (result !== 64'h7F80_0000_0000_7F80 || result !== exp) begin
            errors++;
            $display("FAIL scale_result: got %h expected %h", result, exp);
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL scale_valid: got %b expected 1", result_valid);
        end
        repeat (3) tick();
        checks++;
        if (done !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL scale_hold: done=%b result=%h expected 0 %h", done, result, exp);
        end
    endtask

    task automatic test_length();
        int lat, bc;
        logic [63:0] exp;
        issue(4'd5, 64'h0300_0400_0000_0000, 64'h0, 16'h0);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 22) begin
            errors++;
            $display("FAIL length_latency: got %0d expected 22", lat);
        end
        checks++;
        if (bc !== 21) begin
            errors++;
            $display("FAIL length_busy_cycles: got %0d expected 21", bc);
        end
        checks++;
        if (result !== 64'h0500_0000_0000_0000 || result !== exp) begin
            errors++;
            $display("FAIL length_result: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_add_sub();
        int lat, bc;
        logic [63:0] exp;
        issue(4'd0, 64'h7F00_0001_FF00_8000, 64'h7F00_0002_0200_FFFF, 16'h0);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (result[63:48] !== 16'h7FFF || result !== exp) begin
            errors++;
            $display("FAIL add_result: got %h expected %h", result, exp);
        end
        issue(4'd1, 64'h8000_0100_0005_7FFF, 64'h0100_0200_0003_FF00, 16'h0);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (result[63:48] !== 16'h8000 || result !== exp) begin
            errors++;
            $display("FAIL sub_result: got %h expected %h", result, exp);
        end
        issue(4'd2, 64'h0200_FF00_7F00_8000, 64'h0180_0300_7F00_8000, 16'h0);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp || lat !== 5) begin
            errors++;
            $display("FAIL mul_result: got %h lat %0d expected %h lat 5", result, lat, exp);
        end
    endtask

    task automatic test_dot();
        int lat, bc;
        logic [63:0] exp;
        issue(4'd3, 64'h0100_0200_0300_0400, 64'h0100_0100_0100_0100, 16'h0);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (result !== 64'h0A00_0000_0000_0000 || result !== exp) begin
            errors++;
            $display("FAIL dot_result: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra;
        logic [63:0] exp;
        issue(4'd0, 64'h0100_0200_0300_0400, 64'h0001_0001_0001_0001, 16'h0);
        tick();
        start = 1'b1;
        operation = 4'd1;
        vec_a = 64'h1111_2222_3333_4444;
        tick();
        start = 1'b0;
        wait_done(3, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL ignore_latency: got %0d expected 5", lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL ignore_result: got %h expected %h", result, exp);
        end
        extra = 0;
        repeat (12) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_single_done: got %0d extra dones expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [63:0] exp;
        issue(4'd2, 64'h0200_0300_0400_0500, 64'h0100_0080_0200_FF00, 16'h0);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL b2b_first_result: got %h expected %h", result, exp);
        end
        issue(4'd4, 64'h1234_8000_FFFF_0001, 64'h0, 16'h0300);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b expected 1/0", busy, done);
        end
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected 5", lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL b2b_second_result: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_reserved();
        int lat, bc;
        logic [63:0] exp;
        issue(4'd9, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 16'h5555);
        wait_done(1, lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL reserved_latency: got %0d expected 5", lat);
        end
        checks++;
        if (result !== exp || result !== 64'h0) begin
            errors++;
            $display("FAIL reserved_result: got %h expected 0", result);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [3:0] op;
        logic [63:0] exp;
        for (int n = 0; n < 12; n++) begin
            op = 4'($urandom_range(0, 5));
            issue(op, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
            wait_done(1, lat, bc);
            exp = exp_q.pop_front();
            checks++;
            if (result !== exp || lat !== ((op == 4'd5) ? 22 : 5)) begin
                errors++;
                $display("FAIL random_op%0d: got %h lat %0d expected %h", op, result, lat, exp);
            end
        end
    endtask

    task automatic test_reset_mid_sqrt();
        int dones;
        logic [63:0] dummy;
        issue(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'h0);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_sqrt: busy=%b done=%b rv=%b result=%h expected 0/0/0/0", busy, done, result_valid, result);
        end
        dummy = exp_q.pop_front();
        tick();
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            tick();
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0 (aborted %h)", dones, dummy);
        end
    endtask

    initial begin
        test_reset();
        test_scale();
        test_length();
        test_add_sub();
        test_dot();
        test_ignore_start();
        test_back_to_back();
        test_reserved();
        test_random();
        test_reset_mid_sqrt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
